// File: rtl/agc_mem_pkg.sv
// Shared types, widths and helpers for the erasable memory-cycle sequencer.
package agc_mem_pkg;

    localparam int          RD_CYC_DEF   = 2;
    localparam int          WR_CYC_DEF   = 2;
    localparam int          WIN_CYC_DEF  = 4;
    localparam logic [11:0] SPEC_TOP     = 12'o0060;
    localparam int          ERASABLE_AW  = 11;
    localparam int          WORD_W       = 16;
    localparam int          DATA_W       = WORD_W - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        SENSE   = 3'd2,
        HOLD    = 3'd3,
        RESTORE = 3'd4
    } state_t;

    // Parity bit that makes the 16-bit word carry an odd number of ones.
    function automatic logic odd_par(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/erasable_addr_decode.sv
// Combinational S-address decode: erasable hit test and physical bank/offset address.
module erasable_addr_decode
    import agc_mem_pkg::*;
#(
    parameter logic [11:0] SPEC_TOP_P = SPEC_TOP
) (
    input  logic [11:0]             s_addr,
    input  logic [2:0]              eb,
    output logic                    erasable_hit,
    output logic [ERASABLE_AW-1:0]  phys_addr
);

    logic [2:0] bank;

    // Quarter 3 of erasable space is the switched window selected by EB.
    always_comb begin
        erasable_hit = (s_addr[11:10] == 2'b00) && (s_addr >= SPEC_TOP_P);
        bank         = (s_addr[9:8] == 2'b11) ? eb : {1'b0, s_addr[9:8]};
        phys_addr    = {bank, s_addr[7:0]};
    end

endmodule

// File: rtl/erasable_cycle_seq.sv
// Destructive-readout erasable core sequencer: read, sense/parity, hold for new data, restore.
// Handshake: mcyc_start is accepted only in IDLE with an erasable address; any start while busy is dropped and flagged on cyc_overrun.
module erasable_cycle_seq
    import agc_mem_pkg::*;
#(
    parameter int RD_CYC  = RD_CYC_DEF,
    parameter int WR_CYC  = WR_CYC_DEF,
    parameter int WIN_CYC = WIN_CYC_DEF
) (
    input  logic                    CLOCK,
    input  logic                    rst,
    input  logic                    mcyc_start,
    input  logic [11:0]             s_addr,
    input  logic [2:0]              eb,
    input  logic [WORD_W-1:0]       mem_rdata,
    input  logic                    wl_load,
    input  logic [DATA_W-1:0]       wl_data,
    input  logic                    alarm_clr,
    output logic [ERASABLE_AW-1:0]  mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [WORD_W-1:0]       mem_wdata,
    output logic [DATA_W-1:0]       g_data,
    output logic                    g_valid,
    output logic                    busy,
    output logic                    par_alarm,
    output logic                    cyc_overrun,
    output logic [2:0]              dbg_state
);

    localparam int MAX_RW = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int MAX_C  = (MAX_RW > WIN_CYC) ? MAX_RW : WIN_CYC;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    state_t                   state;
    logic [TW-1:0]            timer;
    logic [DATA_W-1:0]        hold;
    logic [DATA_W-1:0]        hold_next;
    logic                     erasable_hit;
    logic [ERASABLE_AW-1:0]   phys_addr;

    erasable_addr_decode #(
        .SPEC_TOP_P (SPEC_TOP)
    ) u_decode (
        .s_addr       (s_addr),
        .eb           (eb),
        .erasable_hit (erasable_hit),
        .phys_addr    (phys_addr)
    );

    always_comb begin
        hold_next = hold;
        if (wl_load) begin
            hold_next = wl_data;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            hold        <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            g_data      <= '0;
            g_valid     <= 1'b0;
            par_alarm   <= 1'b0;
            cyc_overrun <= 1'b0;
        end else begin
            g_valid     <= 1'b0;
            cyc_overrun <= mcyc_start && (state != IDLE);
            if (alarm_clr) begin
                par_alarm <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (mcyc_start && erasable_hit) begin
                        state    <= READ;
                        mem_addr <= phys_addr;
                        mem_rd   <= 1'b1;
                        timer    <= TW'(RD_CYC - 1);
                    end
                end
                READ: begin
                    if (timer == '0) begin
                        state  <= SENSE;
                        mem_rd <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SENSE: begin
                    g_data  <= mem_rdata[DATA_W-1:0];
                    g_valid <= 1'b1;
                    hold    <= mem_rdata[DATA_W-1:0];
                    // Placed after the clear so a fresh failure beats alarm_clr.
                    if (~^mem_rdata) begin
                        par_alarm <= 1'b1;
                    end
                    state <= HOLD;
                    timer <= TW'(WIN_CYC - 1);
                end
                HOLD: begin
                    hold <= hold_next;
                    if (timer == '0) begin
                        state     <= RESTORE;
                        mem_wr    <= 1'b1;
                        mem_wdata <= {odd_par(hold_next), hold_next};
                        timer     <= TW'(WR_CYC - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RESTORE: begin
                    if (timer == '0) begin
                        state     <= IDLE;
                        mem_wr    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_erasable_cycle_seq.sv
// Scoreboard bench for erasable_cycle_seq: directed scenarios plus randomized memory cycles.
module tb_erasable_cycle_seq;
    import agc_mem_pkg::*;

    localparam int RD  = 2;
    localparam int WR  = 2;
    localparam int WIN = 4;
    localparam int BUSY_LEN = RD + 1 + WIN + WR;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b1;
    logic        mcyc_start = 1'b0;
    logic [11:0] s_addr = '0;
    logic [2:0]  eb = '0;
    logic [15:0] mem_rdata = '0;
    logic        wl_load = 1'b0;
    logic [14:0] wl_data = '0;
    logic        alarm_clr = 1'b0;
    logic [10:0] mem_addr;
    logic        mem_rd, mem_wr, g_valid, busy, par_alarm, cyc_overrun;
    logic [15:0] mem_wdata;
    logic [14:0] g_data;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic model_alarm = 1'b0;

    logic [10:0] exp_addr_q[$];
    logic [14:0] exp_g_q[$];
    logic        exp_alarm_q[$];
    logic [15:0] exp_q[$];
    int          exp_wrlen_q[$];
    int          exp_len_q[$];
    logic        exp_ov_q[$];

    erasable_cycle_seq dut (
        .CLOCK       (CLOCK),
        .rst         (rst),
        .mcyc_start  (mcyc_start),
        .s_addr      (s_addr),
        .eb          (eb),
        .mem_rdata   (mem_rdata),
        .wl_load     (wl_load),
        .wl_data     (wl_data),
        .alarm_clr   (alarm_clr),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .g_data      (g_data),
        .g_valid     (g_valid),
        .busy        (busy),
        .par_alarm   (par_alarm),
        .cyc_overrun (cyc_overrun),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Reference address map: low 1K words, above the special registers; quarter 3 is EB-switched.
    function automatic bit model_erasable(input logic [11:0] a);
        return (int'(a) < 1024) && (int'(a) >= 48);
    endfunction

    function automatic logic [10:0] model_addr(input logic [11:0] a, input logic [2:0] b);
        int q;
        int bank;
        q = int'(a) / 256;
        bank = (q == 3) ? int'(b) : q;
        return 11'(bank * 256 + int'(a) % 256);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_mem_rd"},    mem_rd, 0);
        check({tag, "_mem_wr"},    mem_wr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_g_data"},    g_data, 0);
        check({tag, "_g_valid"},   g_valid, 0);
        check({tag, "_par_alarm"}, par_alarm, 0);
        check({tag, "_overrun"},   cyc_overrun, 0);
        check({tag, "_state"},     dbg_state, IDLE);
    endtask

    // Driver: one full memory cycle; expectations pushed before stimulus.
    task automatic run_cycle(input logic [11:0] a, input logic [2:0] b, input logic [15:0] rd,
                             input logic [3:0] lmask, input logic [3:0][14:0] ld,
                             input bit clr_sense, input int ov_edge, input int rst_edge);
        logic [14:0] final_d;
        bit          bad;
        logic        new_alarm;
        final_d = rd[14:0];
        for (int i = 0; i < 4; i++) if (lmask[i]) final_d = ld[i];
        bad = ($countones(rd) % 2) == 0;
        new_alarm = bad ? 1'b1 : (clr_sense ? 1'b0 : model_alarm);
        model_alarm = new_alarm;
        exp_addr_q.push_back(model_addr(a, b));
        exp_g_q.push_back(rd[14:0]);
        exp_alarm_q.push_back(new_alarm);
        exp_q.push_back({(($countones(final_d) % 2) == 0) ? 1'b1 : 1'b0, final_d});
        exp_len_q.push_back(rst_edge != 0 ? rst_edge : BUSY_LEN);
        exp_wrlen_q.push_back(rst_edge != 0 ? rst_edge - (1 + RD + 1 + WIN) + 1 : WR);

        s_addr = a; eb = b; mem_rdata = rd; mcyc_start = 1'b1;
        tick();
        mcyc_start = 1'b0;
        for (int j = 1; j <= BUSY_LEN; j++) begin
            if (rst_edge != 0 && j == rst_edge) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_alarm = 1'b0;
                check_all_zero("mid_reset");
                return;
            end
            alarm_clr = (j == RD + 1) && clr_sense;
            if (j >= RD + 2 && j <= RD + 1 + WIN) begin
                wl_load = lmask[j - RD - 2];
                wl_data = ld[j - RD - 2];
            end else begin
                wl_load = 1'($urandom_range(0, 1));
                wl_data = 15'($urandom);
            end
            if (j == ov_edge) begin
                mcyc_start = 1'b1;
                s_addr = 12'($urandom_range(48, 1023));
                exp_ov_q.push_back(1'b1);
            end
            tick();
            mcyc_start = 1'b0;
            alarm_clr = 1'b0;
            wl_load = 1'b0;
        end
        check("par_alarm_after_cycle", par_alarm, model_alarm);
        check("busy_after_cycle", busy, 0);
    endtask

    task automatic issue_ignored(input logic [11:0] a);
        s_addr = a; eb = 3'($urandom); mcyc_start = 1'b1;
        tick();
        mcyc_start = 1'b0;
        check("ignored_busy", busy, 0);
        check("ignored_mem_rd", mem_rd, 0);
        tick();
        check("ignored_busy2", busy, 0);
        check("ignored_mem_wr", mem_wr, 0);
    endtask

    task automatic clear_alarm();
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        model_alarm = 1'b0;
        check("alarm_clr", par_alarm, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        logic prev_rd = 1'b0, prev_wr = 1'b0, prev_busy = 1'b0;
        int rd_len = 0, wr_len = 0, busy_len = 0;
        forever begin
            @(negedge CLOCK);
            if (mem_rd && mem_wr) check("rd_wr_exclusive", {mem_rd, mem_wr}, 2'b01);
            if (mem_rd && !prev_rd) begin
                if (exp_addr_q.size() == 0) check("mem_addr_unexpected", 0, 1);
                else check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (mem_rd) rd_len++;
            if (!mem_rd && prev_rd) begin
                check("mem_rd_len", rd_len, RD);
                rd_len = 0;
            end
            if (g_valid) begin
                if (exp_g_q.size() == 0) check("g_valid_unexpected", 0, 1);
                else begin
                    check("g_data", g_data, exp_g_q.pop_front());
                    check("par_alarm_sense", par_alarm, exp_alarm_q.pop_front());
                end
            end
            if (mem_wr) begin
                wr_len++;
                if (exp_q.size() == 0) check("mem_wr_unexpected", 0, 1);
                else check("mem_wdata", mem_wdata, exp_q[0]);
            end
            if (!mem_wr && prev_wr) begin
                if (exp_wrlen_q.size() != 0) check("mem_wr_len", wr_len, exp_wrlen_q.pop_front());
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                wr_len = 0;
            end
            if (busy) busy_len++;
            if (!busy && prev_busy) begin
                if (exp_len_q.size() == 0) check("busy_unexpected", 0, 1);
                else check("busy_len", busy_len, exp_len_q.pop_front());
                check("mem_wdata_idle", mem_wdata, 0);
                busy_len = 0;
            end
            if (cyc_overrun) begin
                if (exp_ov_q.size() == 0) check("overrun_unexpected", 0, 1);
                else void'(exp_ov_q.pop_front());
            end
            prev_rd = mem_rd;
            prev_wr = mem_wr;
            prev_busy = busy;
        end
    end

    // Stimulus
    initial begin
        logic [3:0][14:0] ld;
        logic [11:0]      a;
        ld = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_cycle(12'o0100, 3'b000, 16'h0001, 4'b0000, ld, 1'b0, 0, 0);
        run_cycle(12'o1410, 3'b101, 16'h0007, 4'b0000, ld, 1'b0, 0, 0);
        issue_ignored(12'o0005);
        issue_ignored(12'o2000);
        ld[1] = 15'h1234;
        ld[3] = 15'h0003;
        run_cycle(12'o0523, 3'b010, 16'h0421, 4'b1010, ld, 1'b0, 0, 0);

        run_cycle(12'o0200, 3'b000, 16'h0003, 4'b0000, ld, 1'b0, 0, 0);
        repeat (2) tick();
        check("par_alarm_sticky", par_alarm, 1);
        clear_alarm();
        run_cycle(12'o0300, 3'b000, 16'h0003, 4'b0000, ld, 1'b0, 0, 0);
        run_cycle(12'o0301, 3'b000, 16'h0005, 4'b0000, ld, 1'b1, 0, 0);
        check("par_alarm_set_beats_clr", par_alarm, 1);
        clear_alarm();

        run_cycle(12'o0777, 3'b110, 16'h8000, 4'b0000, ld, 1'b0, 1, 0);
        run_cycle(12'o1777, 3'b111, 16'h0003, 4'b0001, ld, 1'b0, 0, 1 + RD + 1 + WIN + 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 47))
                                                : 12'($urandom_range(1024, 4095));
                issue_ignored(a);
            end else begin
                a = 12'($urandom_range(48, 1023));
                for (int i = 0; i < 4; i++) ld[i] = 15'($urandom);
                run_cycle(a, 3'($urandom), 16'($urandom), 4'($urandom), ld,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, BUSY_LEN)) : 0, 0);
            end
            if ($urandom_range(0, 3) == 0) clear_alarm();
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("addr_q_empty", exp_addr_q.size(), 0);
        check("g_q_empty", exp_g_q.size(), 0);
        check("w_q_empty", exp_q.size(), 0);
        check("len_q_empty", exp_len_q.size(), 0);
        check("ov_q_empty", exp_ov_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
